accum_unit: RTL and testbench



---
 rtl/accum_unit.sv | 189 ++++++++++++++++++
 tb/tb_accum_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_unit.sv
// ---------------------------------------------------------------------------
// accum_unit
//
// Streaming unsigned accumulator. Operand beats arrive over a valid/ready
// handshake. A running sum, a beat count and a sticky carry-out flag are
// kept per packet. When the beat marked last is accepted, the totals are
// presented on the output handshake and held until the consumer takes them.
//
// Per-beat datapath: acc + in_data modulo 2^WIDTH, which is the same result
// the upstream ripple-carry adder produces.
//
// Optional feature macro: ACCUM_SATURATE_EN
//   undefined (default) : sum wraps modulo 2^WIDTH; out_ovf flags the carry
//   defined             : the first carry pins the sum at all-ones for the
//                         rest of the packet; out_ovf is still set
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operand beat present
//   in_ready   out  block can accept a beat (low in HOLD and during reset)
//   in_data    in   WIDTH-bit unsigned operand
//   in_last    in   beat is the final operand of the packet
//   out_valid  out  result available (HOLD state)
//   out_ready  in   consumer takes the result
//   out_sum    out  accumulated sum
//   out_count  out  beats in the packet, including last (saturating)
//   out_ovf    out  sticky carry-out of bit WIDTH-1 within the packet
//   dbg_state  out  current FSM state encoding (0 IDLE, 1 ACCUM, 2 HOLD)
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may be withdrawn at any time
// without losing data, because nothing moves unless both are high.
// ---------------------------------------------------------------------------
module accum_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ACC_ONES = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // Goes high on the first edge after reset release. It keeps in_ready low
  // for the whole reset period and for the cycle in which reset drops, so a
  // beat offered right at release is never taken before the block is live.
  logic               live_q;

  logic               accept;
  logic               out_fire;
  logic [WIDTH-1:0]   sum_raw;
  logic               carry;
  logic [COUNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0]   acc_step;

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  assign in_ready  = live_q & (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Per-beat datapath
  // -------------------------------------------------------------------------
  // Truncated add; a wrapped result is smaller than the old accumulator
  // exactly when the true sum needed bit WIDTH, so the compare recovers the
  // carry without widening the adder.
  assign sum_raw = acc_q + in_data;
  assign carry   = (sum_raw < acc_q);

  // Beat counter sticks at its maximum instead of wrapping to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

`ifdef ACCUM_SATURATE_EN
  // Once any carry has been seen in this packet the sum is pinned at
  // all-ones; ovf_q covers carries from earlier beats, carry this beat.
  assign acc_step = (ovf_q | carry) ? ACC_ONES : sum_raw;
`else
  assign acc_step = sum_raw;
`endif

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        // First beat of a packet loads the registers rather than adding,
        // so nothing from a previous packet can leak into this one.
        if (accept) begin
          acc_d   = in_data;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end

      ACCUM: begin
        if (accept) begin
          acc_d = acc_step;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // Input side is blocked here, so the only event is the result
        // leaving. Clearing on the way out keeps the outputs at zero while
        // idle.
        if (out_fire) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_accum_unit.sv
// ---------------------------------------------------------------------------
// tb_accum_unit
//
// Self-checking bench for accum_unit. Each packet's expected result
// {ovf, count, sum} is produced by a reference model and pushed to exp_q
// when the packet is driven. A monitor pops and compares on every output
// handshake. Scenario tasks also make their own cycle-level checks.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_accum_unit;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam int EW = 1 + CW + W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  pkt[$];
  int            n_cmp;
  int            n_err;
  bit            rand_on;

  accum_unit #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  // Inputs are stable at the falling edge, so valid & ready here means the
  // transfer happens on the next rising edge. That gives one pop per result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [EW-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got sum=%h cnt=%0d ovf=%0b, required none", out_sum, out_count, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_ovf, out_count, out_sum} !== e) begin
          n_err++;
          $display("FAIL sb_result: got sum=%h cnt=%0d ovf=%0b, required sum=%h cnt=%0d ovf=%0b",
                   out_sum, out_count, out_ovf, e[W-1:0], e[W+CW-1:W], e[EW-1]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_pkt();
    logic [W:0]    wide;
    logic [W-1:0]  s;
    logic [CW-1:0] c;
    logic          o;
    s = '0; c = '0; o = 1'b0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == 0) begin
        s = pkt[i];
        c = 1;
      end else begin
        wide = {1'b0, s} + {1'b0, pkt[i]};
        o = o | wide[W];
`ifdef ACCUM_SATURATE_EN
        s = o ? {W{1'b1}} : wide[W-1:0];
`else
        s = wide[W-1:0];
`endif
        if (c != 8'd255) c = c + 1'b1;
      end
    end
    return {o, c, s};
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_beat(input logic [W-1:0] d, input logic l, input int gap);
    bit taken;
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    taken    = 1'b0;
    waited   = 0;
    while (!taken && waited < 200) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = $urandom_range(0, 1);
    if (!taken) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: beat %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic drive_packet(input int max_gap);
    exp_q.push_back(model_pkt());
    for (int i = 0; i < pkt.size(); i++)
      drive_beat(pkt[i], (i == pkt.size() - 1), $urandom_range(0, max_gap));
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b sum=%h cnt=%0d ovf=%0b, required all 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_rise: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    // three beats of a partial packet, then an asynchronous reset mid-ACCUM
    drive_beat(32'd11, 1'b0, 0);
    drive_beat(32'd22, 1'b0, 0);
    drive_beat(32'd33, 1'b0, 0);
    n_cmp++;
    if (out_count !== 8'd3 || out_sum !== 32'd66) begin
      n_err++; $display("FAIL reset_partial: sum=%0d cnt=%0d, required 66/3", out_sum, out_count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: vld=%0b sum=%h cnt=%0d rdy=%0b, required 0/0/0/0",
               out_valid, out_sum, out_count, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pkt = '{32'd5, 32'd7};
    drive_packet(0);
    drain();
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    pkt = '{32'hDEADBEEF};
    exp_q.push_back(model_pkt());
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready_in: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 32'hDEADBEEF || out_count !== 8'd1 ||
        out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: vld=%0b sum=%h cnt=%0d ovf=%0b rdy=%0b, required 1/deadbeef/1/0/0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL single_turnaround: rdy=%0b vld=%0b st=%0d, required 1/0/0", in_ready, out_valid, dbg_state);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    pkt = '{32'hFFFFFFFF, 32'h00000002};
    drive_packet(1);
    n_cmp++;
`ifdef ACCUM_SATURATE_EN
    if (out_sum !== 32'hFFFFFFFF || out_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sat: sum=%h ovf=%0b, required ffffffff/1", out_sum, out_ovf);
    end
`else
    if (out_sum !== 32'h00000001 || out_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap: sum=%h ovf=%0b, required 00000001/1", out_sum, out_ovf);
    end
`endif
    drain();
    // carry on an early beat stays sticky through later non-carrying beats
    pkt = '{32'h80000000, 32'h80000000, 32'd3, 32'd4};
    drive_packet(0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pkt = '{32'd10, 32'd20, 32'd30};
    drive_packet(0);
    pkt = '{32'd99};
    exp_q.push_back(model_pkt());
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 32'd60 || out_count !== 8'd3 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: vld=%0b sum=%0d cnt=%0d rdy=%0b, required 1/60/3/0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== 32'd99) begin
      n_err++; $display("FAIL bp_waiting_beat: vld=%0b sum=%0d, required 1/99", out_valid, out_sum);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          if (rand_on) out_ready = $urandom_range(0, 1);
        end
      end
    join_none
    for (int p = 0; p < 10; p++) begin
      int n;
      n = $urandom_range(1, 8);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back($urandom);
      drive_packet(3);
    end
    drain();
    rand_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
  endtask

  task automatic test_count_saturation();
    out_ready = 1'b1;
    pkt.delete();
    for (int i = 0; i < 300; i++) pkt.push_back(32'd1);
    drive_packet(0);
    @(negedge clk);
    n_cmp++;
    if (out_count !== 8'd255 || out_sum !== 32'd300 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL cnt_sat: sum=%0d cnt=%0d ovf=%0b, required 300/255/0", out_sum, out_count, out_ovf);
    end
    @(posedge clk); #1;
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_err = 0; rand_on = 1'b0;
    test_reset();
    test_single_beat();
    test_overflow();
    test_backpressure();
    test_random();
    test_count_saturation();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
